// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: valid/ready beat carrying a payload plus its GPR write-back tag.
interface pipe_stage_skid_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 5
);
  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data;
  logic                      gpr_we_;
  logic [GPR_ADDR_WIDTH-1:0] dst_addr;
  logic                      is_load;
  modport master (output valid, data, gpr_we_, dst_addr, is_load, input ready);
  modport slave  (input valid, data, gpr_we_, dst_addr, is_load, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: handshaked pipeline register with optional skid entry and per-source hazard hits.
module pipe_stage_skid #(
  parameter int DATA_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int NUM_SRC        = 2,
  parameter bit SKID_EN        = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cpu_en_i,
  input  logic                              flush_i,
  pipe_stage_skid_if.slave                  in_i,
  pipe_stage_skid_if.master                 out_o,
  input  logic [NUM_SRC*GPR_ADDR_WIDTH-1:0] src_addr_i,
  output logic [NUM_SRC-1:0]                fwd_hit_o,
  output logic [NUM_SRC-1:0]                load_hit_o,
  output logic [NUM_SRC-1:0]                skid_hit_o,
  output logic [1:0]                        count_o
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0]     data;
    logic                      gpr_we_;
    logic [GPR_ADDR_WIDTH-1:0] dst;
    logic                      is_load;
  } entry_t;
  state_t state_q, state_d;
  entry_t head_q, head_d, skid_q, skid_d, in_e;
  logic   head_valid, skid_valid, live, push, pop;
  assign in_e       = '{data: in_i.data, gpr_we_: in_i.gpr_we_, dst: in_i.dst_addr, is_load: in_i.is_load};
  assign head_valid = state_q != EMPTY;
  assign skid_valid = SKID_EN && state_q == TWO;
  assign live       = cpu_en_i && !flush_i;
  // Skid mode registers in_ready off occupancy alone, cutting the out_ready -> in_ready path.
  assign in_i.ready   = live && (SKID_EN ? !skid_valid : (!head_valid || out_o.ready));
  assign out_o.valid  = live && head_valid;
  assign push         = in_i.valid && in_i.ready;
  assign pop          = out_o.valid && out_o.ready;
  assign out_o.data     = head_q.data;
  assign out_o.gpr_we_  = head_q.gpr_we_;
  assign out_o.dst_addr = head_q.dst;
  assign out_o.is_load  = head_q.is_load;
  assign count_o        = 2'(state_q);
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (cpu_en_i && flush_i) begin
      state_d = EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          state_d = ONE;
          head_d  = in_e;
        end
        ONE: if (push && pop) head_d = in_e;
          else if (push) begin
            state_d = TWO;
            skid_d  = in_e;
          end else if (pop) state_d = EMPTY;
        TWO: if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_hit
    logic [GPR_ADDR_WIDTH-1:0] src;
    logic                      match_h;
    assign src           = src_addr_i[i*GPR_ADDR_WIDTH +: GPR_ADDR_WIDTH];
    assign match_h       = head_valid && !head_q.gpr_we_ && head_q.dst != '0 && head_q.dst == src;
    assign fwd_hit_o[i]  = match_h && !head_q.is_load;
    assign load_hit_o[i] = match_h && head_q.is_load;
    assign skid_hit_o[i] = skid_valid && !skid_q.gpr_we_ && skid_q.dst != '0 && skid_q.dst == src;
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed vector table for the skid variant plus hand sequences for reset and the no-skid mode.
module tb_pipe_stage_skid;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_en, flush, iv, we, ld, ordy;
  logic [31:0] d;
  logic [4:0]  dst, s0, s1;
  logic [1:0]  fwd1, lh1, sk1, cnt1, fwd0, lh0, sk0, cnt0;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  pipe_stage_skid_if #(.DATA_WIDTH(32), .GPR_ADDR_WIDTH(5)) i1 (), o1 (), i0 (), o0 ();
  assign i1.valid = iv;
  assign i1.data = d;
  assign i1.gpr_we_ = we;
  assign i1.dst_addr = dst;
  assign i1.is_load = ld;
  assign o1.ready = ordy;
  assign i0.valid = iv;
  assign i0.data = d;
  assign i0.gpr_we_ = we;
  assign i0.dst_addr = dst;
  assign i0.is_load = ld;
  assign o0.ready = ordy;
  pipe_stage_skid #(.SKID_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cpu_en_i(cpu_en), .flush_i(flush), .in_i(i1.slave), .out_o(o1.master),
    .src_addr_i({s1, s0}), .fwd_hit_o(fwd1), .load_hit_o(lh1), .skid_hit_o(sk1), .count_o(cnt1));
  pipe_stage_skid #(.SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cpu_en_i(cpu_en), .flush_i(flush), .in_i(i0.slave), .out_o(o0.master),
    .src_addr_i({s1, s0}), .fwd_hit_o(fwd0), .load_hit_o(lh0), .skid_hit_o(sk0), .count_o(cnt0));
  typedef struct {
    logic        en, fl, iv, we, ld, ordy;
    logic [31:0] d;
    logic [4:0]  dst, s0, s1;
    logic        e_ir, e_ov;
    logic [31:0] e_d;
    logic [1:0]  e_cnt, e_fwd, e_ld, e_sk;
  } vec_t;
  vec_t vq[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic en, fl, iv_, input logic [31:0] d_, input logic we_, input logic [4:0] dst_,
                     input logic ld_, ordy_, input logic [4:0] s0_, s1_, input logic e_ir, e_ov,
                     input logic [31:0] e_d, input logic [1:0] e_cnt, e_fwd, e_ld, e_sk);
    vq.push_back('{en, fl, iv_, we_, ld_, ordy_, d_, dst_, s0_, s1_, e_ir, e_ov, e_d, e_cnt, e_fwd, e_ld, e_sk});
  endtask
  task automatic drive(input vec_t v);
    cpu_en = v.en; flush = v.fl; iv = v.iv; d = v.d; we = v.we; dst = v.dst; ld = v.ld; ordy = v.ordy;
    s0 = v.s0; s1 = v.s1;
  endtask
  initial begin
    cpu_en = 1; flush = 0; iv = 0; d = 0; we = 1; dst = 0; ld = 0; ordy = 0; s0 = 0; s1 = 0;
    // streaming 1..8 with out_ready held high
    add(1, 0, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 2; k <= 8; k++) add(1, 0, 1, k, 1, 0, 0, 1, 0, 0, 1, 1, k - 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 8, 1, 0, 0, 0);
    // skid fill: A (alu, dst 5) then B (load, dst 7) under back-pressure, C rejected
    add(1, 0, 1, 'hA, 0, 5, 0, 0, 5, 0, 1, 0, 8, 0, 0, 0, 0);
    add(1, 0, 1, 'hB, 0, 7, 1, 0, 5, 7, 1, 1, 'hA, 1, 2'b01, 0, 0);
    add(1, 0, 1, 'hC, 0, 3, 0, 0, 5, 7, 0, 1, 'hA, 2, 2'b01, 0, 2'b10);
    add(1, 0, 0, 0, 1, 0, 0, 1, 5, 7, 0, 1, 'hA, 2, 2'b01, 0, 2'b10);
    add(1, 0, 0, 0, 1, 0, 0, 1, 5, 7, 1, 1, 'hB, 1, 0, 2'b10, 0);
    // fill two again, then flush masked by cpu_en = 0, then a real flush
    add(1, 0, 1, 'h11, 0, 5, 1, 0, 5, 7, 1, 0, 'hB, 0, 0, 0, 0);
    add(1, 0, 1, 'h22, 0, 0, 0, 0, 5, 7, 1, 1, 'h11, 1, 0, 2'b01, 0);
    add(0, 1, 1, 'h33, 0, 7, 0, 0, 5, 7, 0, 0, 'h11, 2, 0, 2'b01, 0);
    add(1, 1, 1, 'h33, 0, 7, 0, 0, 5, 7, 0, 0, 'h11, 2, 0, 2'b01, 0);
    add(1, 0, 0, 0, 1, 0, 0, 1, 5, 7, 1, 0, 0, 0, 0, 0, 0);
    // dst 0 never produces a hit
    add(1, 0, 1, 'h44, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 'h44, 1, 0, 0, 0);
    add(1, 0, 1, 'h55, 0, 9, 0, 0, 0, 9, 1, 1, 'h44, 1, 0, 0, 0);
    @(negedge clk);
    #2;
    chk("rst_count", 32'(cnt1), 0);
    chk("rst_out_valid", 32'(o1.valid), 0);
    chk("rst_fields", {o1.data, 3'(o1.gpr_we_), 5'(o1.dst_addr), 3'(o1.is_load)} == '0, 1);
    chk("rst_hits", {fwd1, lh1, sk1}, 0);
    rst_n = 1;
    #1;
    chk("rst_in_ready", 32'(i1.ready), 1);
    foreach (vq[n]) begin
      @(negedge clk);
      drive(vq[n]);
      #2;
      chk($sformatf("v%0d_in_ready", n), 32'(i1.ready), 32'(vq[n].e_ir));
      chk($sformatf("v%0d_out_valid", n), 32'(o1.valid), 32'(vq[n].e_ov));
      chk($sformatf("v%0d_out_data", n), o1.data, vq[n].e_d);
      chk($sformatf("v%0d_count", n), 32'(cnt1), 32'(vq[n].e_cnt));
      chk($sformatf("v%0d_hits", n), {fwd1, lh1, sk1}, {vq[n].e_fwd, vq[n].e_ld, vq[n].e_sk});
    end
    // last vector pushed 0x55 behind 0x44: two entries held, then reset between edges
    @(negedge clk);
    iv = 0;
    #2;
    chk("pre_rst_count", 32'(cnt1), 2);
    chk("pre_rst_skid_hit", 32'(sk1), 2);
    rst_n = 0;
    #1;
    chk("async_rst_count", 32'(cnt1), 0);
    chk("async_rst_out", {o1.data, 3'(o1.gpr_we_), 5'(o1.dst_addr), 3'(o1.is_load)}, 0);
    chk("async_rst_valid_hits", {o1.valid, fwd1, lh1, sk1}, 0);
    // single-entry mode: in_ready follows out_ready combinationally
    @(negedge clk);
    rst_n = 1;
    iv = 1; d = 'h66; we = 1; dst = 0; ld = 0; ordy = 0; s0 = 0; s1 = 0;
    #2;
    chk("ns_empty_in_ready", 32'(i0.ready), 1);
    @(negedge clk);
    d = 'h77;
    #2;
    chk("ns_full_in_ready", 32'(i0.ready), 0);
    chk("ns_head", o0.data, 'h66);
    ordy = 1;
    #1;
    chk("ns_comb_in_ready", 32'(i0.ready), 1);
    chk("ns_out_valid", 32'(o0.valid), 1);
    @(negedge clk);
    iv = 0; ordy = 0;
    #2;
    chk("ns_next_data", o0.data, 'h77);
    chk("ns_count", 32'(cnt0), 1);
    chk("ns_in_ready_stall", 32'(i0.ready), 0);
    chk("ns_no_skid_hit", {sk0, fwd0, lh0}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
